// File: rtl/i2c_eeprom_target.sv
// rtl/i2c_eeprom_target.sv - I2C target emulating a small byte-addressed serial EEPROM
module i2c_eeprom_target #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         DEPTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     scl_i,
   input  logic                     sda_i,
   output logic                     sda_o,
   output logic                     sda_oe,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [7:0]               cfg_data,
   output logic                     busy,
   output logic [7:0]               ptr
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WPTR, S_WDATA, S_RDATA, S_RACK
   } state_t;

   state_t          state_q, state_d;
   logic            scl_s1_q, scl_s2_q, scl_h_q, scl_s1_d, scl_s2_d, scl_h_d;
   logic            sda_s1_q, sda_s2_q, sda_h_q, sda_s1_d, sda_s2_d, sda_h_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      sh_q, sh_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            sda_oe_q, sda_oe_d;
   logic            busy_q, busy_d;
   logic            ack_pend_q, ack_pend_d;   // ACK owed: drive low at next SCL fall
   logic            ack_q, ack_d;             // inside 9th clock: next SCL fall starts a byte
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];

   logic            scl_rise, scl_fall, start_c, stop_c;
   logic            rx_state, rx_bit, rx_done, addr_hit, rd_bit_phase;
   logic [7:0]      rx_byte;
   logic [AW-1:0]   ptr_inc;

   assign sda_o  = 1'b0;
   assign sda_oe = sda_oe_q;
   assign busy   = busy_q;
   assign ptr    = 8'(ptr_q);

   // Bus events are decoded from the synchronized samples against their history flops
   assign scl_rise     = scl_s2_q & ~scl_h_q;
   assign scl_fall     = ~scl_s2_q & scl_h_q;
   assign start_c      = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
   assign stop_c       = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
   assign rx_state     = (state_q == S_ADDR) || (state_q == S_WPTR) || (state_q == S_WDATA);
   assign rx_bit       = scl_rise & rx_state & ~ack_pend_q & ~ack_q;
   assign rx_done      = rx_bit & (bit_cnt_q == 4'd7);
   assign rx_byte      = {sh_q[6:0], sda_s2_q};
   assign addr_hit     = (rx_byte[7:1] == DEV_ADDR);
   assign rd_bit_phase = (state_q == S_RDATA) & ~ack_pend_q & ~ack_q;
   assign ptr_inc      = ptr_q + AW'(1);

   // Synchronizer and history stages for both bus lines
   always_comb begin
      scl_s1_d = scl_i;
      scl_s2_d = scl_s1_q;
      scl_h_d  = scl_s2_q;
      sda_s1_d = sda_i;
      sda_s2_d = sda_s1_q;
      sda_h_d  = sda_s2_q;
   end

   // State register and all datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_h_q    <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_h_q    <= 1'b1;
         bit_cnt_q  <= '0;
         sh_q       <= '0;
         ptr_q      <= '0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         ack_pend_q <= 1'b0;
         ack_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         scl_s1_q   <= scl_s1_d;
         scl_s2_q   <= scl_s2_d;
         scl_h_q    <= scl_h_d;
         sda_s1_q   <= sda_s1_d;
         sda_s2_q   <= sda_s2_d;
         sda_h_q    <= sda_h_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         ack_pend_q <= ack_pend_d;
         ack_q      <= ack_d;
         mem_q      <= mem_d;
      end
   end

   // Next-state logic: START/STOP override everything, then per-byte progress
   always_comb begin
      state_d = state_q;
      if (start_c) begin
         state_d = S_ADDR;
      end else if (stop_c) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_ADDR:  if (rx_done) state_d = !addr_hit ? S_IDLE : (rx_byte[0] ? S_RDATA : S_WPTR);
            S_WPTR:  if (rx_done) state_d = S_WDATA;
            S_RDATA: if (scl_fall && rd_bit_phase && bit_cnt_q == 4'd8) state_d = S_RACK;
            S_RACK:  if (scl_rise) state_d = sda_s2_q ? S_IDLE : S_RDATA;
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs and datapath: shifting, ACK slot timing, pointer and memory updates
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      ack_pend_d = ack_pend_q;
      ack_d      = ack_q;
      mem_d      = mem_q;
      if (start_c || stop_c) begin
         bit_cnt_d  = '0;
         sda_oe_d   = 1'b0;
         busy_d     = 1'b0;
         ack_pend_d = 1'b0;
         ack_d      = 1'b0;
      end else begin
         if (rx_bit) begin
            sh_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
         if (rx_done) begin
            bit_cnt_d = '0;
            case (state_q)
               S_ADDR: if (addr_hit) begin
                  busy_d     = 1'b1;
                  ack_pend_d = 1'b1;
                  if (rx_byte[0]) sh_d = mem_q[ptr_q];
               end
               S_WPTR: begin
                  ptr_d      = rx_byte[AW-1:0];
                  ack_pend_d = 1'b1;
               end
               S_WDATA: begin
                  mem_d[ptr_q] = rx_byte;
                  ptr_d        = ptr_inc;
                  ack_pend_d   = 1'b1;
               end
               default: ;
            endcase
         end
         // SDA only ever moves on an SCL fall so the master never sees it change while SCL is high
         if (scl_fall && ack_pend_q) begin
            sda_oe_d   = 1'b1;
            ack_pend_d = 1'b0;
            ack_d      = 1'b1;
         end else if (scl_fall && ack_q) begin
            ack_d     = 1'b0;
            bit_cnt_d = '0;
            sda_oe_d  = (state_q == S_RDATA) ? ~sh_q[7] : 1'b0;
         end else if (scl_fall && rd_bit_phase) begin
            if (bit_cnt_q == 4'd8) begin
               sda_oe_d  = 1'b0;
               bit_cnt_d = '0;
            end else begin
               sh_d     = {sh_q[6:0], 1'b0};
               sda_oe_d = ~sh_q[6];
            end
         end
         if (scl_rise && rd_bit_phase) bit_cnt_d = bit_cnt_q + 4'd1;
         if (scl_rise && state_q == S_RACK) begin
            ptr_d = ptr_inc;
            if (sda_s2_q) begin
               busy_d = 1'b0;
            end else begin
               sh_d  = mem_q[ptr_inc];
               ack_d = 1'b1;
            end
         end
      end
      // Preload is applied last so it overrides a same-cycle bus write
      if (cfg_we) mem_d[cfg_addr] = cfg_data;
   end
endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb/tb_i2c_eeprom_target.sv - self-checking bench for i2c_eeprom_target
module tb_i2c_eeprom_target;
   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       sda_o, sda_oe;
   logic       cfg_we;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       busy;
   logic [7:0] ptr;

   int tests = 0;
   int fails = 0;
   int oe_cnt = 0;

   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] p;
      logic [7:0] e;
   } rd_vec_t;
   rd_vec_t vt[4];

   assign sda_bus = sda_m & ~sda_oe;

   i2c_eeprom_target #(.DEV_ADDR(7'h50), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_o(sda_o), .sda_oe(sda_oe), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .busy(busy), .ptr(ptr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (sda_oe) oe_cnt = oe_cnt + 1;

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: run did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic i2c_start();
      wait_cyc(4); sda_m = 1'b1;
      wait_cyc(4); scl_m = 1'b1;
      wait_cyc(8); sda_m = 1'b0;
      wait_cyc(8); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_cyc(4); sda_m = 1'b0;
      wait_cyc(4); scl_m = 1'b1;
      wait_cyc(8); sda_m = 1'b1;
      wait_cyc(8);
   endtask

   // one SCL period; coll lands a preload of byte 3 in the cycle the target acts on this rise
   task automatic bit_xfer(input logic b, input bit coll, output logic r);
      wait_cyc(4); sda_m = b;
      wait_cyc(4); r = sda_bus; scl_m = 1'b1;
      if (coll) begin
         wait_cyc(2);
         cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 8'hFF;
         wait_cyc(1);
         cfg_we = 1'b0;
         wait_cyc(5);
      end else begin
         wait_cyc(8);
      end
      scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, input bit coll, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], coll && i == 0, r);
      bit_xfer(1'b1, 1'b0, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic ack_m, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, 1'b0, r);
         d[i] = r;
      end
      bit_xfer(~ack_m, 1'b0, r);
   endtask

   task automatic random_read(input logic [7:0] p, input int n);
      logic       a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, 1'b0, a); check("wr_hdr_ack", a, 1);
      write_byte(p, 1'b0, a);     check("ptr_ack", a, 1);
      i2c_start();
      write_byte(8'hA1, 1'b0, a); check("rd_hdr_ack", a, 1);
      check("busy_in_read", busy, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(i != n - 1, d);
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rd_data: got %0h, expected nothing queued", d);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (d !== e) begin
               fails++;
               $display("FAIL rd_data: got %0h, expected %0h", d, e);
            end
         end
      end
      check("busy_after_nack", busy, 0);
      i2c_stop();
   endtask

   initial begin
      logic a;
      int   oe0;
      vt[0] = '{8'h0E, 8'h11};
      vt[1] = '{8'h0F, 8'h22};
      vt[2] = '{8'h00, 8'h33};
      vt[3] = '{8'h01, 8'h3C};

      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      wait_cyc(5);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_sda_o", sda_o, 0);
      check("rst_busy", busy, 0);
      check("rst_ptr", ptr, 0);
      rst = 1'b0;
      wait_cyc(5);

      // preload then random read of two bytes
      cfg_write(4'd0, 8'hA5);
      cfg_write(4'd1, 8'h3C);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      random_read(8'h00, 2);
      check("ptr_after_read", ptr, 2);

      // write with wrap-around
      i2c_start();
      write_byte(8'hA0, 1'b0, a); check("w_hdr_ack", a, 1);
      check("busy_in_write", busy, 1);
      write_byte(8'h0E, 1'b0, a); check("w_ptr_ack", a, 1);
      write_byte(8'h11, 1'b0, a); check("w_d0_ack", a, 1);
      write_byte(8'h22, 1'b0, a); check("w_d1_ack", a, 1);
      write_byte(8'h33, 1'b0, a); check("w_d2_ack", a, 1);
      i2c_stop();
      check("ptr_after_wrap", ptr, 1);
      check("busy_after_stop", busy, 0);

      // wrong device address
      oe0 = oe_cnt;
      i2c_start();
      write_byte(8'hA2, 1'b0, a); check("bad_hdr_nack", a, 0);
      write_byte(8'h55, 1'b0, a); check("bad_data_nack", a, 0);
      check("bad_busy", busy, 0);
      i2c_stop();
      check("bad_oe_cycles", oe_cnt - oe0, 0);

      // memory contents via table of single-byte random reads
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(vt[i].e);
         random_read(vt[i].p, 1);
      end

      // read across the top of memory
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h3C);
      random_read(8'h0F, 3);
      check("ptr_after_top_read", ptr, 2);

      // reset while the target drives a read bit low
      i2c_start();
      write_byte(8'hA0, 1'b0, a); check("r_hdr_ack", a, 1);
      write_byte(8'h0E, 1'b0, a); check("r_ptr_ack", a, 1);
      i2c_start();
      write_byte(8'hA1, 1'b0, a); check("r_rd_ack", a, 1);
      wait_cyc(5);
      check("pre_rst_oe", sda_oe, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_oe", sda_oe, 0);
      check("mid_rst_ptr", ptr, 0);
      check("mid_rst_busy", busy, 0);
      rst = 1'b0;
      i2c_stop();
      i2c_start();
      write_byte(8'hA0, 1'b0, a); check("post_hdr_ack", a, 1);
      write_byte(8'h05, 1'b0, a); check("post_ptr_ack", a, 1);
      write_byte(8'h77, 1'b0, a); check("post_data_ack", a, 1);
      i2c_stop();
      exp_q.push_back(8'h77);
      random_read(8'h05, 1);
      exp_q.push_back(8'h00);
      random_read(8'h0E, 1);

      // preload collides with bus write of the same byte
      i2c_start();
      write_byte(8'hA0, 1'b0, a); check("c_hdr_ack", a, 1);
      write_byte(8'h03, 1'b0, a); check("c_ptr_ack", a, 1);
      write_byte(8'h00, 1'b1, a); check("c_data_ack", a, 1);
      i2c_stop();
      check("c_ptr", ptr, 4);
      exp_q.push_back(8'hFF);
      random_read(8'h03, 1);

      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
